// File: rtl/data_path.sv
// -----------------------------------------------------------------------------
// data_path -- bit-serial unsigned adder
//
// Adds two WIDTH-bit unsigned operands with a single 1-bit full adder and a
// carry flip-flop, LSB first. A request on go (sampled in IDLE) captures A and
// B. The result appears on sum, with the carry-out in sum[WIDTH], WIDTH+2
// rising edges after the edge that sampled go. sum holds between completions.
//
// Ports:
//   clk   in   1        rising-edge clock for all state
//   rst   in   1        asynchronous active-high reset
//   A     in   WIDTH    first operand (captured at start only)
//   B     in   WIDTH    second operand (captured at start only)
//   go    in   1        start request, level-sampled while IDLE
//   sum   out  WIDTH+1  registered result of the last completed addition
//   done  out  1        one-cycle completion pulse (only with DATA_PATH_DONE_EN)
//
// Build option:
//   DATA_PATH_DONE_EN  when defined, adds the done output and its register.
// -----------------------------------------------------------------------------
module data_path #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             go,
`ifdef DATA_PATH_DONE_EN
  output logic [WIDTH:0]   sum,
  output logic             done
`else
  output logic [WIDTH:0]   sum
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  // The one full adder, fed by the operand LSBs and the carry flop.
  logic s_bit;
  logic c_out;

  always_comb begin
    s_bit = a_sh[0] ^ b_sh[0] ^ carry;
    c_out = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  // NOTE: every flop here uses non-blocking assignments and sits in the async
  // reset branch, so a reset mid-addition clears all partial state at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            a_sh  <= A;
            b_sh  <= B;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          // WIDTH bit-steps, then one edge to notice the count is exhausted;
          // this gives the WIDTH+2 edge start-to-sum latency.
          if (cnt == CNT_MAX) begin
            state <= DONE;
          end else begin
            res   <= {s_bit, res[WIDTH-1:1]};
            carry <= c_out;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            cnt   <= cnt + CW'(1);
          end
        end
        DONE: begin
          sum   <= {carry, res};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATA_PATH_DONE_EN
  // High for the single cycle after the edge that loads sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
    end
  end
`endif

endmodule

// File: tb/tb_data_path.sv
// -----------------------------------------------------------------------------
// tb_data_path -- self-checking bench for data_path (WIDTH = 8)
//
// A reference model tracks the pending sum A+B captured at start and the
// number of edges until it must appear on sum; outputs are compared every
// cycle on the falling clock edge. Directed scenarios cover the listed cases
// (basic add, overflow, zeros, go held high, operand change during an add,
// reset mid-addition), followed by randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_data_path;

  localparam int W       = 8;
  localparam int LATENCY = W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic         go  = 1'b0;
  logic [W:0]   sum;
`ifdef DATA_PATH_DONE_EN
  logic         done;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int         m_rem  = 0;   // edges left until the pending result lands
  logic [W:0] m_pend = '0;
  logic [W:0] m_sum  = '0;
  logic       m_done = 1'b0;

  data_path #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .go  (go),
`ifdef DATA_PATH_DONE_EN
    .sum (sum),
    .done(done)
`else
    .sum (sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem  = 0;
    m_pend = '0;
    m_sum  = '0;
    m_done = 1'b0;
  endtask

  // One rising edge as seen by the model, given the inputs present at it.
  task automatic model_edge(input logic [W-1:0] ai, input logic [W-1:0] bi,
                            input logic gi);
    m_done = 1'b0;
    if (m_rem == 0) begin
      if (gi) begin
        m_pend = {1'b0, ai} + {1'b0, bi};
        m_rem  = LATENCY;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_sum  = m_pend;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, ".sum"}, 32'(sum), 32'(m_sum));
`ifdef DATA_PATH_DONE_EN
    check({tag, ".done"}, 32'(done), 32'(m_done));
`endif
  endtask

  // Drive inputs during the low phase, clock once, compare on the falling edge.
  task automatic step(input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic gi, input string tag);
    a  = ai;
    b  = bi;
    go = gi;
    @(posedge clk);
    model_edge(ai, bi, gi);
    @(negedge clk);
    compare_outputs(tag);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++)
      step(W'($urandom), W'($urandom), 1'b0, tag);
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must clear before any edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_outputs({tag, ".async"});
    @(posedge clk);
    @(negedge clk);
    compare_outputs({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    // Power-on reset.
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 7 + 15 = 22, sum stays 0 until the completion edge, then holds.
    step(8'd7, 8'd15, 1'b1, "add7_15");
    idle_steps(LATENCY + 4, "add7_15");
    check("add7_15.final", 32'(sum), 32'd22);

    // Overflow: 255 + 255 = 510 with carry in the MSB.
    step(8'd255, 8'd255, 1'b1, "ovf");
    idle_steps(LATENCY + 2, "ovf");
    check("ovf.final", 32'(sum), 32'h1FE);

    // Zero operands.
    step(8'd0, 8'd0, 1'b1, "zero");
    idle_steps(LATENCY + 2, "zero");

    // go held high: back-to-back recomputation of 5 + 6.
    for (int i = 0; i < 15; i++) step(8'd5, 8'd6, 1'b1, "goheld");
    idle_steps(LATENCY + 2, "goheld");
    check("goheld.final", 32'(sum), 32'd11);

    // Operands change after the start: result still uses captured values.
    step(8'd2, 8'd3, 1'b1, "latch");
    step(8'd2, 8'd3, 1'b0, "latch");
    for (int i = 0; i < LATENCY + 2; i++) step(8'd100, 8'd77, 1'b0, "latch");
    check("latch.final", 32'(sum), 32'd5);

    // Previous result 11, then start 7 + 15 and reset during the addition.
    step(8'd5, 8'd6, 1'b1, "prev");
    idle_steps(LATENCY + 1, "prev");
    step(8'd7, 8'd15, 1'b1, "abort");
    idle_steps(3, "abort");
    pulse_reset("abort.rst");
    idle_steps(LATENCY + 2, "abort.after");
    check("abort.no22", 32'(sum), 32'd0);
    step(8'd7, 8'd15, 1'b1, "restart");
    idle_steps(LATENCY + 1, "restart");
    check("restart.final", 32'(sum), 32'd22);

    // Randomized traffic with sporadic resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rnd.rst");
      end else begin
        step(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
